// File: rtl/key_pkg.sv
// Shared types and helpers for the key event front end.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } key_state_t;

   // Counter width able to hold 0..x; never narrower than one bit.
   function automatic int cnt_w(input int x);
      return (x < 1) ? 1 : $clog2(x + 1);
   endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop sync, tick-based debounce, and press/long/repeat/release event FSM.
//   state   | meaning
//   IDLE    | debounced level released, waiting for accepted press
//   PRESSED | pressed, counting ticks towards the long event
//   HELD    | long event emitted, counting ticks between repeats
module key_channel
   import key_pkg::*;
#(
   parameter int STABLE_CNT = 3,
   parameter int LONG_CNT   = 100,
   parameter int REPEAT_CNT = 20,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tick,
   input  logic i_key,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);

   localparam int SW = cnt_w(STABLE_CNT);
   localparam int LW = cnt_w(LONG_CNT);
   localparam int RW = cnt_w(REPEAT_CNT);
   localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CNT - 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CNT - 1);
   localparam logic [RW-1:0] REP_LAST  = (REPEAT_CNT > 0) ? RW'(REPEAT_CNT - 1) : '0;

   logic          r_sync1;
   logic          r_sync2;
   logic [SW-1:0] r_stb_cnt;
   logic [LW-1:0] r_hold_cnt;
   logic [RW-1:0] r_rep_cnt;
   key_state_t    r_state;

   logic w_s;
   logic w_diff;
   logic w_toggle;
   logic w_rise;
   logic w_fall;

   assign w_s      = r_sync2 ^ ACTIVE_LOW;
   assign w_diff   = i_tick && (w_s != o_level);
   assign w_toggle = w_diff && (r_stb_cnt == STB_LAST);
   assign w_rise   = w_toggle && !o_level;
   assign w_fall   = w_toggle && o_level;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= ACTIVE_LOW;
         r_sync2 <= ACTIVE_LOW;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stb_cnt <= '0;
         o_level   <= 1'b0;
      end else if (i_tick) begin
         if (!w_diff) begin
            r_stb_cnt <= '0;
         end else if (w_toggle) begin
            r_stb_cnt <= '0;
            o_level   <= !o_level;
         end else begin
            r_stb_cnt <= r_stb_cnt + SW'(1);
         end
      end
   end

   // Events act on the same tick as the level change so pulses align with the new level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         o_press    <= 1'b0;
         o_release  <= 1'b0;
         o_long     <= 1'b0;
         o_repeat   <= 1'b0;
      end else begin
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
         o_repeat  <= 1'b0;
         if (i_tick) begin
            case (r_state)
               IDLE: begin
                  if (w_rise) begin
                     o_press    <= 1'b1;
                     r_hold_cnt <= '0;
                     r_state    <= PRESSED;
                  end
               end
               PRESSED: begin
                  if (w_fall) begin
                     o_release  <= 1'b1;
                     r_hold_cnt <= '0;
                     r_state    <= IDLE;
                  end else if (r_hold_cnt == LONG_LAST) begin
                     o_long     <= 1'b1;
                     r_hold_cnt <= '0;
                     r_rep_cnt  <= '0;
                     r_state    <= HELD;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + LW'(1);
                  end
               end
               HELD: begin
                  if (w_fall) begin
                     o_release <= 1'b1;
                     r_rep_cnt <= '0;
                     r_state   <= IDLE;
                  end else if (REPEAT_CNT > 0) begin
                     if (r_rep_cnt == REP_LAST) begin
                        o_repeat  <= 1'b1;
                        r_rep_cnt <= '0;
                     end else begin
                        r_rep_cnt <= r_rep_cnt + RW'(1);
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/key_event_proc.sv
// Multi-key front end: shared sample tick generator feeding one key_channel per key.
module key_event_proc
   import key_pkg::*;
#(
   parameter int KEY_NUM    = 4,
   parameter int SMP_INTV   = 1_000_000,
   parameter int STABLE_CNT = 3,
   parameter int LONG_CNT   = 100,
   parameter int REPEAT_CNT = 20,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [KEY_NUM-1:0] i_key,
   output logic [KEY_NUM-1:0] o_key_level,
   output logic [KEY_NUM-1:0] o_key_press,
   output logic [KEY_NUM-1:0] o_key_release,
   output logic [KEY_NUM-1:0] o_key_long,
   output logic [KEY_NUM-1:0] o_key_repeat
);

   localparam int TW = cnt_w(SMP_INTV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SMP_INTV - 1);

   logic [TW-1:0] r_smp_cnt;
   logic          w_tick;

   assign w_tick = (r_smp_cnt == TICK_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst || w_tick) begin
         r_smp_cnt <= '0;
      end else begin
         r_smp_cnt <= r_smp_cnt + TW'(1);
      end
   end

   for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
      key_channel #(
         .STABLE_CNT (STABLE_CNT),
         .LONG_CNT   (LONG_CNT),
         .REPEAT_CNT (REPEAT_CNT),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_tick    (w_tick),
         .i_key     (i_key[g]),
         .o_level   (o_key_level[g]),
         .o_press   (o_key_press[g]),
         .o_release (o_key_release[g]),
         .o_long    (o_key_long[g]),
         .o_repeat  (o_key_repeat[g])
      );
   end

endmodule

// File: tb/tb_key_event_proc.sv
// Directed bench: active-high DUT (a) and active-low, no-repeat DUT (b); ticks every 4 clks.
module tb_key_event_proc;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] key_a = 2'b00;
   logic [1:0] key_b = 2'b11;
   logic [1:0] lvl_a, press_a, rel_a, long_a, rep_a;
   logic [1:0] lvl_b, press_b, rel_b, long_b, rep_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int np_a[2] = '{0, 0};
   int nr_a[2] = '{0, 0};
   int nl_a[2] = '{0, 0};
   int nrp_a[2] = '{0, 0};
   int np_b = 0, nr_b = 0, nl_b = 0, nrp_b = 0;

   always #5 clk = ~clk;

   key_event_proc #(
      .KEY_NUM(2), .SMP_INTV(4), .STABLE_CNT(3), .LONG_CNT(5), .REPEAT_CNT(2), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_key(key_a),
      .o_key_level(lvl_a), .o_key_press(press_a), .o_key_release(rel_a),
      .o_key_long(long_a), .o_key_repeat(rep_a)
   );

   key_event_proc #(
      .KEY_NUM(2), .SMP_INTV(4), .STABLE_CNT(3), .LONG_CNT(5), .REPEAT_CNT(0), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_key(key_b),
      .o_key_level(lvl_b), .o_key_press(press_b), .o_key_release(rel_b),
      .o_key_long(long_b), .o_key_repeat(rep_b)
   );

   // cyc = posedges since reset released; ticks update state on posedges where cyc % 4 == 0
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            np_a[k]  += int'(press_a[k]);
            nr_a[k]  += int'(rel_a[k]);
            nl_a[k]  += int'(long_a[k]);
            nrp_a[k] += int'(rep_a[k]);
         end
         np_b  += int'(press_b[0]);
         nr_b  += int'(rel_b[0]);
         nl_b  += int'(long_b[0]);
         nrp_b += int'(rep_b[0]);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc < n) begin
         @(negedge clk);
         guard++;
         if (guard > 5000) begin
            n_err++;
            $display("FAIL wait_cyc: cyc %0d never reached %0d", cyc, n);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $fatal(1, "cycle budget exhausted");
         end
      end
      if (cyc != n) begin
         n_err++;
         $display("FAIL wait_cyc: at cyc %0d wanted %0d", cyc, n);
      end
   endtask

   int s_np, s_nr, s_nl, s_nrp;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_out_a", {lvl_a, press_a, rel_a, long_a, rep_a}, 10'h000);
      chk("reset_out_b", {lvl_b, press_b, rel_b, long_b, rep_b}, 10'h000);

      // 1: clean press/release on key 0
      key_a = 2'b01;
      wait_cyc(11); chk("t1_lvl_pre", lvl_a, 2'b00); chk("t1_press_pre", press_a, 2'b00);
      wait_cyc(12); chk("t1_press", press_a, 2'b01); chk("t1_lvl", lvl_a, 2'b01);
      wait_cyc(13); chk("t1_press_one", press_a, 2'b00);
      wait_cyc(40); key_a = 2'b00;
      wait_cyc(51); chk("t1_lvl_held", lvl_a, 2'b01); chk("t1_rel_pre", rel_a, 2'b00);
      wait_cyc(52); chk("t1_rel", rel_a, 2'b01); chk("t1_lvl_rel", lvl_a, 2'b00);
      wait_cyc(53);
      chk("t1_npress", np_a[0], 1); chk("t1_nrel", nr_a[0], 1);
      chk("t1_key1_quiet", np_a[1] + nr_a[1] + nl_a[1] + nrp_a[1], 0);

      // 2: bounce pattern 1,1,0 per tick never reaches three in a row
      s_np = np_a[0]; s_nr = nr_a[0];
      for (int i = 0; i < 12; i++) begin
         wait_cyc(53 + 4 * i);
         chk("t2_lvl", lvl_a[0], 1'b0);
         key_a[0] = (i % 3 != 2);
      end
      wait_cyc(101); key_a = 2'b00;
      wait_cyc(104); chk("t2_lvl_end", lvl_a[0], 1'b0);
      chk("t2_npress", np_a[0] - s_np, 0); chk("t2_nrel", nr_a[0] - s_nr, 0);

      // 3: long + repeat; release tick coincides with a due repeat
      s_np = np_a[0]; s_nr = nr_a[0]; s_nl = nl_a[0]; s_nrp = nrp_a[0];
      wait_cyc(105); key_a = 2'b01;
      wait_cyc(116); chk("t3_press", press_a, 2'b01);
      wait_cyc(135); chk("t3_long_pre", long_a, 2'b00);
      wait_cyc(136); chk("t3_long", long_a, 2'b01);
      wait_cyc(144); chk("t3_rep_first", rep_a, 2'b01);
      wait_cyc(189); key_a = 2'b00;
      wait_cyc(199); chk("t3_lvl_pre", lvl_a, 2'b01);
      wait_cyc(200); chk("t3_rel", rel_a, 2'b01); chk("t3_rep_suppr", rep_a, 2'b00);
      chk("t3_lvl_rel", lvl_a, 2'b00);
      wait_cyc(230);
      chk("t3_npress", np_a[0] - s_np, 1); chk("t3_nrel", nr_a[0] - s_nr, 1);
      chk("t3_nlong", nl_a[0] - s_nl, 1); chk("t3_nrep", nrp_a[0] - s_nrp, 7);

      // 4: simultaneous keys
      wait_cyc(233); key_a = 2'b11;
      wait_cyc(243); chk("t4_press_pre", press_a, 2'b00);
      wait_cyc(244); chk("t4_press", press_a, 2'b11);
      wait_cyc(245); key_a = 2'b01;
      wait_cyc(255); chk("t4_rel_pre", rel_a, 2'b00);
      wait_cyc(256); chk("t4_rel", rel_a, 2'b10); chk("t4_lvl", lvl_a, 2'b01);

      // 5: reset while key 0 is HELD
      wait_cyc(270);
      s_nr = nr_a[0];
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_reset_out", {lvl_a, press_a, rel_a, long_a, rep_a}, 10'h000);
      s_np = np_b; s_nr = nr_a[0]; s_nl = nl_b; s_nrp = nrp_b;
      wait_cyc(11); chk("t5_lvl_pre", lvl_a[0], 1'b0);
      wait_cyc(12); chk("t5_press", press_a, 2'b01);

      // 6: active-low DUT with repeat disabled
      wait_cyc(13);
      chk("t5_no_rel", nr_a[0] - s_nr, 0);
      key_b = 2'b10;
      wait_cyc(23); chk("t6_lvl_pre", lvl_b, 2'b00);
      wait_cyc(24); chk("t6_press", press_b, 2'b01);
      wait_cyc(44); chk("t6_long", long_b, 2'b01);
      wait_cyc(61); key_b = 2'b11;
      wait_cyc(71); chk("t6_lvl_held", lvl_b, 2'b01);
      wait_cyc(72); chk("t6_rel", rel_b, 2'b01); chk("t6_lvl_rel", lvl_b, 2'b00);
      wait_cyc(80);
      chk("t6_npress", np_b - s_np, 1); chk("t6_nlong", nl_b - s_nl, 1);
      chk("t6_nrep", nrp_b - s_nrp, 0); chk("t6_nrel", nr_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
